// File: rtl/prog_sequencer.sv
// -----------------------------------------------------------------------------
// prog_sequencer
//
// Program buffer and instruction scheduler in front of cpu_core. A program is
// loaded as 4-bit nibbles (MSB nibble first) and assembled into 16-bit words
// stored in a DEPTH-entry buffer. Instructions are issued one at a time: each
// issue presents {opcode, instr} and pulses inst_done, then the block waits for
// the core's core_done pulse before advancing pc. Runs single-step or auto-run,
// guarded by a watchdog that parks the block in HALT with a sticky error.
//
// Handshake: inst_done is a one-cycle "instruction available" strobe; opcode
// and instr are valid in that cycle and hold until the next issue. The core
// answers with a one-cycle core_done strobe, which is only accepted in WAIT.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   load_valid/nibble   nibble strobe and data, accepted in IDLE when not full
//   clear               empty the program buffer (IDLE only)
//   run                 start auto-run (level, sampled in IDLE)
//   step_edge           issue a single instruction (pulse, sampled in IDLE)
//   stop                abort to IDLE from any state, clears timeout_err
//   core_done           completion pulse from the core
//   opcode, instr       issued instruction bits [15:12] and [11:0]
//   inst_done           one-cycle issue strobe
//   busy                high in ISSUE or WAIT
//   pc                  index of the next or current instruction
//   prog_len, full      number of stored instructions, prog_len == DEPTH
//   timeout_err         sticky watchdog error
// -----------------------------------------------------------------------------
module prog_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_valid,
    input  logic [3:0]                 load_nibble,
    input  logic                       clear,
    input  logic                       run,
    input  logic                       step_edge,
    input  logic                       stop,
    input  logic                       core_done,
    output logic [3:0]                 opcode,
    output logic [11:0]                instr,
    output logic                       inst_done,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic [$clog2(DEPTH):0]     prog_len,
    output logic                       full,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state, state_d;
    logic            auto_q, auto_d;
    logic [15:0]     asm_q, asm_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [WW-1:0]   wd_q, wd_d;

    logic [3:0]      opcode_d;
    logic [11:0]     instr_d;
    logic            inst_done_d;
    logic            busy_d;
    logic [AW-1:0]   pc_d;
    logic [LW-1:0]   len_d;
    logic            full_d;
    logic            err_d;

    logic [15:0]     mem [DEPTH];
    logic            mem_we;
    logic [15:0]     mem_wdata;

    // Next pc with wrap at the end of the loaded program.
    logic [LW-1:0]   pc_inc;
    logic            wrap;
    logic [AW-1:0]   pc_next;

    assign pc_inc  = {1'b0, pc} + LW'(1);
    assign wrap    = (pc_inc == prog_len);
    assign pc_next = wrap ? '0 : pc_inc[AW-1:0];
    assign mem_wdata = {asm_q[11:0], load_nibble};

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        auto_d      = auto_q;
        asm_d       = asm_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        opcode_d    = opcode;
        instr_d     = instr;
        inst_done_d = 1'b0;
        busy_d      = busy;
        pc_d        = pc;
        len_d       = prog_len;
        err_d       = timeout_err;
        mem_we      = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b0;
            // Only an abort from IDLE discards a half-assembled word.
            if (state == S_IDLE) begin
                cnt_d = '0;
                asm_d = '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        len_d = '0;
                        pc_d  = '0;
                        cnt_d = '0;
                        asm_d = '0;
                    end else begin
                        if (load_valid && !full) begin
                            asm_d = mem_wdata;
                            cnt_d = cnt_q + 2'd1;
                            if (cnt_q == 2'd3) begin
                                mem_we = 1'b1;
                                len_d  = prog_len + LW'(1);
                            end
                        end
                        if ((prog_len != '0) && (run || step_edge)) begin
                            state_d               = S_ISSUE;
                            auto_d                = run;
                            {opcode_d, instr_d}   = mem[pc];
                            inst_done_d           = 1'b1;
                            busy_d                = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state_d = S_WAIT;
                    wd_d    = '0;
                end
                S_WAIT: begin
                    if (core_done) begin
                        pc_d = pc_next;
                        if (auto_q && !wrap) begin
                            state_d             = S_ISSUE;
                            {opcode_d, instr_d} = mem[pc_next];
                            inst_done_d         = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else if (wd_q == WW'(TIMEOUT - 1)) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
                end
                S_HALT: begin
                    // Parked until stop.
                end
                default: state_d = S_IDLE;
            endcase
        end

        full_d = (len_d == LW'(DEPTH));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            auto_q      <= 1'b0;
            asm_q       <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            opcode      <= '0;
            instr       <= '0;
            inst_done   <= 1'b0;
            busy        <= 1'b0;
            pc          <= '0;
            prog_len    <= '0;
            full        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            auto_q      <= auto_d;
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            opcode      <= opcode_d;
            instr       <= instr_d;
            inst_done   <= inst_done_d;
            busy        <= busy_d;
            pc          <= pc_d;
            prog_len    <= len_d;
            full        <= full_d;
            timeout_err <= err_d;
        end
    end

    // Program storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_len[AW-1:0]] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prog_sequencer
//
// Table of directed vectors for loading, stepping, auto-run and ignored
// events, followed by hand-written sequences for auto-run turnaround, full
// buffer, partial-word abort, watchdog timeout and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_prog_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [3:0]  load_nibble;
    logic        clear;
    logic        run;
    logic        step_edge;
    logic        stop;
    logic        core_done;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done;
    logic        busy;
    logic [2:0]  pc;
    logic [3:0]  prog_len;
    logic        full;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    prog_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_nibble (load_nibble),
        .clear       (clear),
        .run         (run),
        .step_edge   (step_edge),
        .stop        (stop),
        .core_done   (core_done),
        .opcode      (opcode),
        .instr       (instr),
        .inst_done   (inst_done),
        .busy        (busy),
        .pc          (pc),
        .prog_len    (prog_len),
        .full        (full),
        .timeout_err (timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [3:0]  nib;
        logic        clr;
        logic        rn;
        logic        stp_e;
        logic        stp;
        logic        cd;
        logic [15:0] word;
        logic        idn;
        logic        bsy;
        logic [2:0]  pcv;
        logic [3:0]  len;
        logic        fl;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic lv, logic [3:0] nib, logic clr, logic rn,
                                logic stp_e, logic stp, logic cd,
                                logic [15:0] word, logic idn, logic bsy,
                                logic [2:0] pcv, logic [3:0] len, logic fl,
                                logic err);
        vec_t v;
        v.lv = lv; v.nib = nib; v.clr = clr; v.rn = rn; v.stp_e = stp_e;
        v.stp = stp; v.cd = cd; v.word = word; v.idn = idn; v.bsy = bsy;
        v.pcv = pcv; v.len = len; v.fl = fl; v.err = err;
        return v;
    endfunction

    function automatic logic [26:0] outs();
        return {opcode, instr, inst_done, busy, pc, prog_len, full, timeout_err};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid  = 1'b0;
        load_nibble = 4'h0;
        clear       = 1'b0;
        run         = 1'b0;
        step_edge   = 1'b0;
        stop        = 1'b0;
        core_done   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_word(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            load_valid  = 1'b1;
            load_nibble = w[15 - 4*i -: 4];
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_core_done();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic pulse_step();
        step_edge = 1'b1;
        tick();
        step_edge = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [15:0] w;
        logic [26:0] exp_o;

        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("reset_outputs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Vector table: inputs applied for one edge, outputs checked after it.
        //             lv nib   clr rn st sp cd  word     idn bsy pc len fl er
        vecs.push_back(mk(1, 4'h8, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h2, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 4'h1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 4'hA, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 4'h5, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 2, 0, 0));
        // single step of word 0
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 0, 0, 16'h8123, 1, 1, 0, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 16'h8123, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 16'h8123, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 16'h8123, 0, 0, 1, 2, 0, 0));
        // step word 1; core_done during ISSUE and load during WAIT are ignored
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 0, 0, 16'h1A05, 1, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 16'h1A05, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 16'h1A05, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 0, 16'h1A05, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 16'h1A05, 0, 0, 0, 2, 0, 0));
        // run and step together: auto mode chains into word 1
        vecs.push_back(mk(0, 4'h0, 0, 1, 1, 0, 0, 16'h8123, 1, 1, 0, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 16'h8123, 0, 1, 0, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 16'h1A05, 1, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 16'h1A05, 0, 1, 1, 2, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 1, 16'h1A05, 0, 0, 0, 2, 0, 0));
        // clear wins over run; step on an empty buffer does nothing
        vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0, 0, 16'h1A05, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 1, 0, 0, 16'h1A05, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            load_valid  = vecs[i].lv;
            load_nibble = vecs[i].nib;
            clear       = vecs[i].clr;
            run         = vecs[i].rn;
            step_edge   = vecs[i].stp_e;
            stop        = vecs[i].stp;
            core_done   = vecs[i].cd;
            tick();
            exp_o = {vecs[i].word, vecs[i].idn, vecs[i].bsy, vecs[i].pcv,
                     vecs[i].len, vecs[i].fl, vecs[i].err};
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(exp_o));
        end
        idle_inputs();

        // ---- auto-run of 3 instructions, core_done 4 cycles after each issue
        do_reset();
        load_word(16'h2001);
        load_word(16'h3002);
        load_word(16'h4003);
        chk("auto_len", 32'(prog_len), 32'd3);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("auto_issue0", {15'h0, inst_done, opcode, instr}, {15'h0, 1'b1, 16'h2001});
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("auto_pulse_width%0d", k), 32'(inst_done), 32'd0);
            tick();
            tick();
            pulse_core_done();
            if (k < 2) begin
                w = (k == 0) ? 16'h3002 : 16'h4003;
                chk($sformatf("auto_issue%0d", k + 1),
                    {12'h0, inst_done, busy, pc, opcode, instr},
                    {12'h0, 1'b1, 1'b1, 3'(k + 1), w});
            end else begin
                chk("auto_end", {28'h0, inst_done, busy, pc}, {28'h0, 1'b0, 1'b0, 3'd0});
            end
        end

        // ---- full buffer: DEPTH words plus 4 dropped nibbles
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_word({4'(i + 1), 12'(i * 3 + 5)});
        end
        chk("full_len", {27'h0, full, prog_len}, {27'h0, 1'b1, 4'd8});
        load_word(16'hFFFF);
        chk("full_drop", {27'h0, full, prog_len}, {27'h0, 1'b1, 4'd8});
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            pulse_core_done();
        end
        chk("full_last_word", {16'h0, opcode, instr}, {16'h0, 4'd8, 12'(7 * 3 + 5)});
        tick();
        pulse_core_done();
        chk("full_wrap", {28'h0, busy, pc}, {28'h0, 1'b0, 3'd0});
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear", {27'h0, full, prog_len}, {27'h0, 1'b0, 4'd0});

        // ---- stop in IDLE drops a partial word
        load_valid  = 1'b1;
        load_nibble = 4'hA;
        tick();
        load_nibble = 4'hB;
        tick();
        load_valid = 1'b0;
        pulse_stop();
        load_word(16'h5678);
        chk("partial_len", 32'(prog_len), 32'd1);
        pulse_step();
        chk("partial_word", {15'h0, inst_done, opcode, instr}, {15'h0, 1'b1, 16'h5678});
        pulse_stop();

        // ---- watchdog timeout
        do_reset();
        load_word(16'h7111);
        load_word(16'h6222);
        pulse_step();
        tick();
        pulse_core_done();
        chk("to_pc1", 32'(pc), 32'd1);
        pulse_step();
        tick();  // WAIT entered at this edge
        for (int j = 1; j < TIMEOUT; j++) begin
            tick();
        end
        chk("to_before", {30'h0, timeout_err, busy}, {30'h0, 1'b0, 1'b1});
        tick();
        chk("to_set", {28'h0, timeout_err, busy, pc}, {28'h0, 1'b1, 1'b0, 3'd1});
        pulse_core_done();
        chk("to_late_done", {28'h0, timeout_err, busy, pc}, {28'h0, 1'b1, 1'b0, 3'd1});
        pulse_step();
        chk("to_halt_hold", {30'h0, timeout_err, inst_done}, {30'h0, 1'b1, 1'b0});
        pulse_stop();
        chk("to_stop", {28'h0, timeout_err, busy, pc}, {28'h0, 1'b0, 1'b0, 3'd1});
        pulse_step();
        chk("to_restep", {15'h0, inst_done, opcode, instr}, {15'h0, 1'b1, 16'h6222});
        pulse_stop();

        // ---- asynchronous reset mid auto-run
        do_reset();
        load_word(16'h9abc);
        load_word(16'hdef0);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(outs()), 32'h0);
        #1;
        rst_n = 1'b1;
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        chk("rst_run_ignored", {27'h0, busy, prog_len}, {27'h0, 1'b0, 4'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
